// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: resolves per-stage stall and flush requests into
// pipeline-register hold (stall), NOP-insert (bubble) and clear (flush)
// controls. Flushes whose stage is frozen are parked in a pending vector
// and applied once that stage advances. Also carries a consecutive-stall
// watchdog and a wrapping stall-cycle counter.
//
// Handshake: none. The control vectors are pure combinational levels that
// are valid every cycle. Requests are sampled at the rising edge only for
// the pending/watchdog/counter state.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 16,
    parameter int MAX_STALL  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic [NUM_STAGES-1:0] flushreq,
    input  logic                  clr_timeout,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  stall_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [NUM_STAGES-1:0] o_dbg_pend
);

    localparam logic [15:0] MAX_W = 16'(MAX_STALL);

    logic [NUM_STAGES-1:0] r_pend;
    logic [15:0]           r_wd_cnt;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_stall_cnt;

    // w_frozen[i]: some stage at or above i is stalled, so stage i cannot move.
    // w_app_ge[i]: an applicable flush exists at index i or above (i <= f).
    logic [NUM_STAGES-1:0] w_frozen;
    logic [NUM_STAGES-1:0] w_freq;
    logic [NUM_STAGES-1:0] w_app;
    logic [NUM_STAGES-1:0] w_app_ge;
    logic [NUM_STAGES-1:0] w_pend_next;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_bubble;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_any_flush;
    logic                  w_any_stall;
    logic                  w_to_set;

    // Priority resolution: oldest applicable flush beats every stall.
    always_comb begin
        w_frozen    = '0;
        w_freq      = flushreq | r_pend;
        w_app       = '0;
        w_app_ge    = '0;
        w_stall     = '0;
        w_bubble    = '0;
        w_flush     = '0;
        w_frozen[NUM_STAGES-1] = stallreq[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_frozen[i] = w_frozen[i+1] | stallreq[i];
        end
        w_app = w_freq & ~w_frozen;
        w_app_ge[NUM_STAGES-1] = w_app[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_app_ge[i] = w_app_ge[i+1] | w_app[i];
        end
        w_any_flush = w_app_ge[0];
        // Everything at or below f is either applied or killed.
        w_pend_next = w_freq & ~w_app_ge;
        if (rst) begin
            if (w_any_flush) begin
                for (int j = 0; j < NUM_STAGES - 1; j++) begin
                    w_flush[j] = w_app_ge[j+1];
                end
            end else begin
                w_stall = w_frozen;
                // Bubble goes just above the highest stalled stage.
                for (int j = 1; j < NUM_STAGES; j++) begin
                    w_bubble[j] = stallreq[j-1] & ~w_frozen[j];
                end
            end
        end
        w_any_stall = |w_stall;
        w_to_set    = w_any_stall && (r_wd_cnt == MAX_W - 16'd1);
    end

    // Pending flushes, watchdog and stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= '0;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_any_stall) begin
                if (r_wd_cnt != MAX_W) begin
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                end
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_wd_cnt <= '0;
            end
            // A set in the same cycle as a clear wins.
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (clr_timeout) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign stall         = w_stall;
    assign bubble        = w_bubble;
    assign flush         = w_flush;
    assign stall_timeout = r_timeout;
    assign stall_cnt     = r_stall_cnt;
    assign o_dbg_pend    = r_pend;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for an N-stage in-order core; successor to the fixed two-bit ID/MEM stall priority logic. It resolves per-stage stall and flush requests into per-stage `stall`, `bubble` and `flush` controls. Flushes that cannot be applied because the requesting stage is frozen are held until they can be applied. It also provides a stall watchdog and a stall-cycle performance counter. It sits beside the pipeline registers and drives their enable/clear inputs.

## Interface
- `NUM_STAGES`, 5: pipeline depth. Stage 0 is the youngest (IF); stage NUM_STAGES-1 is the oldest (WB). Legal range is 2..16.
- `CNT_W`, 16: width of the stall-cycle counter.
- `MAX_STALL`, 255: consecutive-stall cycle limit for the watchdog. Must be at least 1 and fit in 16 bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stallreq`  in  NUM_STAGES  bit i: stage i cannot advance this cycle. Level signal.
- `flushreq`  in  NUM_STAGES  bit i: one-cycle pulse; kill every stage younger than i.
- `clr_timeout`  in  1  synchronous clear of `stall_timeout`.
- `stall`  out  NUM_STAGES  bit j: hold pipeline register j.
- `bubble`  out  NUM_STAGES  bit j: load a NOP into stage j.
- `flush`  out  NUM_STAGES  bit j: clear stage j.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cnt`  out  CNT_W  count of cycles with any `stall` bit set. Wraps.

## Operation
- State:
  - `pend[NUM_STAGES-1:0]`: deferred flushes.
  - `wd_cnt`: 16-bit consecutive-stall counter, saturating.
  - `stall_timeout`.
  - `stall_cnt`.
- Stall level `h` is the highest index with `stallreq[h]`=1. If no bit is set, there is no stall.
- Effective flush request: `F` = `flushreq | pend`.
- A flush at index i is applicable when `stallreq[k]`=0 for every k ≥ i, i.e. stage i itself advances.
- `f` is the highest applicable index in `F`. Bits of `F` that are set but not applicable are deferred.
- If some `f` exists:
  - `flush[j]`=1 for all j<f; `flush[j]`=0 for j≥f.
  - `stall`=0 and `bubble`=0. An applied flush always cancels stalls, because the stall level is necessarily below f.
- Otherwise, if a stall level h exists:
  - `stall[j]`=1 for j≤h.
  - `bubble[h+1]`=1 if h+1<NUM_STAGES; all other `bubble` bits are 0.
  - `flush`=0.
- Otherwise all three control vectors are 0.
- `pend` update at each edge:
  - `pend_next` = `F` with bit f cleared and all bits below f cleared, since those instructions are killed.
  - Bits above f are kept. A new pulse on an already-pending bit merges into it (OR).
- Watchdog:
  - `wd_cnt` increments on each cycle with any `stall` bit set and clears to 0 on a cycle with no stall.
  - It saturates at MAX_STALL.
  - `stall_timeout` sets on the edge where `wd_cnt` reaches MAX_STALL and stays set until `clr_timeout` or reset.
  - If `clr_timeout` and a set condition occur in the same cycle, the set wins.
- `stall_cnt` increments on each cycle with any `stall` bit set and wraps modulo 2^CNT_W.

## Timing
- `stall`, `bubble` and `flush` are combinational from the inputs and the current `pend`, so they take effect in the same cycle as the request. There are no registered outputs on the control path.
- A deferred flush is applied in the first cycle in which its stage is no longer frozen. That is one or more cycles after the pulse.
- While `rst`=0:
  - `stall`, `bubble` and `flush` are forced to 0.
  - `pend`, `wd_cnt`, `stall_timeout` and `stall_cnt` are 0.
- Reset asserted mid-operation discards all pending flushes immediately (asynchronously).
- The first edge after `rst` rises performs a normal update.
- Both `stallreq` and `flushreq` set on the same stage i: the flush from i is not applicable and is deferred; the stall is honoured.
- Multiple applicable flushes in one cycle: only the oldest (highest index) is applied. Younger pending bits are cleared.

## Test plan
All scenarios use NUM_STAGES=5 and MAX_STALL=4.
1. `stallreq`=00010 → `stall`=00011, `bubble`=00100, `flush`=0, `stall_cnt` +1 per cycle.
2. `stallreq`=01010 → `stall`=01111, `bubble`=10000. `stallreq`=10000 → `stall`=11111, `bubble`=0.
3. `flushreq`=00100 pulse with no stall → `flush`=00011 in the same cycle, `stall`=0, `pend` stays 0.
4. `stallreq[3]` held for cycles 1-3 and `flushreq[2]` pulsed in cycle 1:
   - Cycles 1-3: `stall`=01111, `flush`=0, `pend`=00100.
   - Cycle 4, `stallreq`=0: `flush`=00011, and `pend`=0 after that edge.
5. `flushreq`=01010 with `stallreq`=00100 → `flush`=00111, `stall`=0, `pend`=0 after the edge.
6. `stallreq[1]` held for 4 cycles → `stall_timeout`=1 after the 4th edge. It stays 1 after `stallreq` drops and clears one edge after a `clr_timeout` pulse. A subsequent `rst` low pulse during a deferred flush → all outputs and counters read 0 and no flush fires after release.
